game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
//  Game-state sequencer on the slow leg clock. Tracks IDLE/RUN/OVER, counts score in BCD,
//  and raises the speed level. Drives game_over into the goose renderer's check_hit input,
//  which freezes the goose; score/level also feed the HUD and obstacle scroller.
//  Consumes the collision detector's sticky hit flag.
// PARAMETERS
//  DIGITS      4    BCD score digits (score_bcd width = 4*DIGITS)
//  SPEED_STEP  100  RUN ticks per level increment (>=2)
//  MAX_LEVEL   7    level saturation value (fits 3 bits)
// PORTS
//  clk_leg      in   1         clock, leg-animation rate; all logic rises on it
//  reset        in   1         synchronous, active-high
//  btn_start    in   1         jump button level, async to clk_leg
//  hit          in   1         sticky collision flag, level, held until reset
//  running      out  1         1 while state==RUN
//  game_over    out  1         1 while state==OVER (-> goose check_hit)
//  score_bcd    out  4*DIGITS  current score, packed BCD, digit0 = LSBs
//  level        out  3         speed level 0..MAX_LEVEL
//  level_up     out  1         one-cycle pulse on each level increment
//  hi_score_bcd out  4*DIGITS  best score (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; running=0, game_over=0, score=0, level=0, level_up=0, tick=0,
//   sync flops=0, btn_prev=0; hi_score also 0. Reset has priority over everything, mid-RUN included.
//  Inputs: btn_start and hit each pass a 2-flop synchronizer. start_edge = btn_s & ~btn_prev.
//  IDLE: score/level/tick held at 0; start_edge -> RUN.
//  RUN : on every edge that stays in RUN: score += 1 (BCD ripple carry, saturates at all-9s);
//        tick += 1; at tick==SPEED_STEP-1, tick->0 and, if level<MAX_LEVEL, level+=1 and
//        level_up=1 in the same cycle. At MAX_LEVEL tick still wraps; level_up stays 0.
//        hit_s==1 -> OVER; that edge does not increment score/tick/level (hit wins over count).
//  OVER: score/level frozen; game_over=1. start_edge only if hit_s==0 -> IDLE (clears score,
//        level, tick); with hit_s still 1 it stays OVER (renderer needs reset to clear).
//  Latency: hit rising before edge N -> hit_s at N+1 -> game_over=1 after edge N+2.
//   btn_start to running: same 2-edge sync plus 1 edge.
//  Outputs are registered; running/game_over decode from the state register, never both 1.
//  BCD digits never exceed 9; level never exceeds MAX_LEVEL; illegal state code -> IDLE.
// CONFIGURATION
//  GAME_HISCORE_EN defined: on the RUN->OVER edge, if score_bcd > hi_score_bcd (unsigned
//   compare is valid for packed BCD), hi_score_bcd <= score_bcd. Cleared by reset only.
//  Not defined: hi_score_bcd tied to 0, no compare logic.
// STRUCTURE
//  game_defs.vh: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_OVER=2'd2; BCD_NINE=4'd9.
//  Sub-module bcd_digit: one 4-bit digit with inc_in/carry_out/sat. Instantiate DIGITS of
//   them in a generate chain. FSM, tick/level counter and synchronizers stay in game_ctrl.
// TESTING
//  1 reset, btn_start pulse held 3 edges -> running=1 by the 4th edge; score counts 1,2,3 per edge
//  2 RUN 250 edges, SPEED_STEP=100 -> score=0x0250, level=2, level_up pulsed at ticks 100 and 200
//  3 hit asserted at score 0x0042 -> game_over=1 two edges later; score frozen at 0x0044 (sync lag)
//  4 force score 0x9998, run 3 edges -> 0x9999, 0x9999 (saturation); level capped at 7
//  5 GAME_HISCORE_EN: game1 ends 0x0120, game2 ends 0x0080 -> hi_score stays 0x0120
//  6 reset asserted mid-RUN with hit=1 -> next edge all outputs 0, state IDLE

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the game-state sequencer: state encodings, BCD limits and level width.
// Imported by the interface, the BCD digit cell and the game_ctrl top.
package game_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   localparam logic [3:0] BCD_NINE = 4'd9;
   localparam int         LEVEL_W  = 3;

   // Codes above nine cannot occur, but are treated as saturated so a corrupt digit self-heals.
   function automatic logic bcdIsMax(input logic [3:0] digit);
      return (digit >= BCD_NINE);
   endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Bundle of the game controller's player/collision inputs and HUD/renderer outputs.
// The slave modport is the controller; the master modport is whatever drives and observes it.
interface game_ctrl_if
   import game_ctrl_pkg::*;
#(
   parameter int DIGITS = 4
) ();

   logic                    btn_start;
   logic                    hit;
   logic                    running;
   logic                    game_over;
   logic [4*DIGITS-1:0]     score_bcd;
   logic [LEVEL_W-1:0]      level;
   logic                    level_up;
   logic [4*DIGITS-1:0]     hi_score_bcd;

   modport master (
      output btn_start,
      output hit,
      input  running,
      input  game_over,
      input  score_bcd,
      input  level,
      input  level_up,
      input  hi_score_bcd
   );

   modport slave (
      input  btn_start,
      input  hit,
      output running,
      output game_over,
      output score_bcd,
      output level,
      output level_up,
      output hi_score_bcd
   );

endinterface

// File: rtl/game_ctrl_bcd_digit.sv
// One registered BCD digit of the score: increments on inc_i, wraps 9->0 with carry_o,
// and reports sat_o while it holds nine so the top can saturate the whole score.
module bcd_digit
   import game_ctrl_pkg::*;
(
   input  logic       clk_leg,
   input  logic       reset,
   input  logic       clr_i,
   input  logic       inc_i,
   output logic [3:0] digit_o,
   output logic       carry_o,
   output logic       sat_o
);

   logic [3:0] digit_q;
   logic [3:0] digit_d;

   always_comb begin
      digit_d = digit_q;
      if (clr_i) begin
         digit_d = 4'd0;
      end else if (inc_i) begin
         digit_d = bcdIsMax(digit_q) ? 4'd0 : (digit_q + 4'd1);
      end
   end

   always_ff @(posedge clk_leg) begin
      if (reset) begin
         digit_q <= 4'd0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit_o = digit_q;
   assign sat_o   = bcdIsMax(digit_q);
   assign carry_o = inc_i & sat_o;

endmodule

// File: rtl/game_ctrl.sv
// Game-state sequencer on the leg clock: IDLE/RUN/OVER, saturating BCD score, speed level.
// Optional high-score tracking is enabled by defining GAME_HISCORE_EN.
module game_ctrl
   import game_ctrl_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int SPEED_STEP = 100,
   parameter int MAX_LEVEL  = 7
) (
   input  logic       clk_leg,
   input  logic       reset,
   game_ctrl_if.slave bus
);

   localparam int                  TICK_W    = (SPEED_STEP > 2) ? $clog2(SPEED_STEP) : 1;
   localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(SPEED_STEP - 1);
   localparam logic [LEVEL_W-1:0]  LEVEL_TOP = LEVEL_W'(MAX_LEVEL);

   state_t               state_q;
   state_t               state_d;

   logic                 btnMeta_q;
   logic                 btnSync_q;
   logic                 btnPrev_q;
   logic                 hitMeta_q;
   logic                 hitSync_q;
   logic                 startEdge;

   logic [TICK_W-1:0]    tick_q;
   logic [TICK_W-1:0]    tick_d;
   logic [LEVEL_W-1:0]   level_q;
   logic [LEVEL_W-1:0]   level_d;
   logic                 levelUp_q;
   logic                 levelUp_d;

   logic                 countEn;
   logic                 clearAll;

   logic [DIGITS:0]      ripple;
   logic [DIGITS-1:0]    satVec;
   logic [4*DIGITS-1:0]  scoreVec;

   // Both asynchronous inputs get two flops; btnPrev_q turns the button level into a press edge.
   always_ff @(posedge clk_leg) begin
      if (reset) begin
         btnMeta_q <= 1'b0;
         btnSync_q <= 1'b0;
         btnPrev_q <= 1'b0;
         hitMeta_q <= 1'b0;
         hitSync_q <= 1'b0;
      end else begin
         btnMeta_q <= bus.btn_start;
         btnSync_q <= btnMeta_q;
         btnPrev_q <= btnSync_q;
         hitMeta_q <= bus.hit;
         hitSync_q <= hitMeta_q;
      end
   end

   assign startEdge = btnSync_q & ~btnPrev_q;

   always_ff @(posedge clk_leg) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A collision takes precedence over counting on the edge it is seen; leaving OVER needs hit clear.
   always_comb begin
      state_d  = state_q;
      countEn  = 1'b0;
      clearAll = 1'b0;
      case (state_q)
         ST_IDLE: begin
            clearAll = 1'b1;
            if (startEdge) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (hitSync_q) begin
               state_d = ST_OVER;
            end else begin
               countEn = 1'b1;
            end
         end
         ST_OVER: begin
            if (startEdge && !hitSync_q) begin
               state_d  = ST_IDLE;
               clearAll = 1'b1;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            clearAll = 1'b1;
         end
      endcase
   end

   always_comb begin
      tick_d    = tick_q;
      level_d   = level_q;
      levelUp_d = 1'b0;
      if (clearAll) begin
         tick_d  = '0;
         level_d = '0;
      end else if (countEn) begin
         if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (level_q < LEVEL_TOP) begin
               level_d   = level_q + LEVEL_W'(1);
               levelUp_d = 1'b1;
            end
         end else begin
            tick_d = tick_q + TICK_W'(1);
         end
      end
   end

   always_ff @(posedge clk_leg) begin
      if (reset) begin
         tick_q    <= '0;
         level_q   <= '0;
         levelUp_q <= 1'b0;
      end else begin
         tick_q    <= tick_d;
         level_q   <= level_d;
         levelUp_q <= levelUp_d;
      end
   end

   // The score stops at all nines by withholding the increment from the least significant digit.
   assign ripple[0] = countEn & ~(&satVec);

   for (genvar g = 0; g < DIGITS; g++) begin : gDigit
      bcd_digit uDigit (
         .clk_leg (clk_leg),
         .reset   (reset),
         .clr_i   (clearAll),
         .inc_i   (ripple[g]),
         .digit_o (scoreVec[4*g +: 4]),
         .carry_o (ripple[g+1]),
         .sat_o   (satVec[g])
      );
   end

   assert property (@(posedge clk_leg) disable iff (reset) !ripple[DIGITS]);

`ifdef GAME_HISCORE_EN
   logic [4*DIGITS-1:0] hiScore_q;
   logic [4*DIGITS-1:0] hiScore_d;

   // Packed BCD orders the same as binary, so a plain unsigned compare picks the better score.
   always_comb begin
      hiScore_d = hiScore_q;
      if ((state_q == ST_RUN) && (state_d == ST_OVER) && (scoreVec > hiScore_q)) begin
         hiScore_d = scoreVec;
      end
   end

   always_ff @(posedge clk_leg) begin
      if (reset) begin
         hiScore_q <= '0;
      end else begin
         hiScore_q <= hiScore_d;
      end
   end

   assign bus.hi_score_bcd = hiScore_q;
`else
   assign bus.hi_score_bcd = '0;
`endif

   assign bus.running   = (state_q == ST_RUN);
   assign bus.game_over = (state_q == ST_OVER);
   assign bus.score_bcd = scoreVec;
   assign bus.level     = level_q;
   assign bus.level_up  = levelUp_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: start latency, BCD counting, level steps, hit freeze,
// saturation, high-score retention and reset priority.
module tb_game_ctrl;

   logic clk_leg;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

`ifdef GAME_HISCORE_EN
   localparam logic [15:0] HI_AFTER_G1 = 16'h0120;
   localparam logic [15:0] HI_AFTER_G2 = 16'h0120;
`else
   localparam logic [15:0] HI_AFTER_G1 = 16'h0000;
   localparam logic [15:0] HI_AFTER_G2 = 16'h0000;
`endif

   game_ctrl_if #(.DIGITS(4)) bus ();

   game_ctrl #(
      .DIGITS     (4),
      .SPEED_STEP (100),
      .MAX_LEVEL  (7)
   ) dut (
      .clk_leg (clk_leg),
      .reset   (reset),
      .bus     (bus)
   );

   initial clk_leg = 1'b0;
   always #5 clk_leg = ~clk_leg;

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic stepEdge();
      @(posedge clk_leg);
      #1;
   endtask

   task automatic applyStimulus(input logic btn, input logic h);
      bus.btn_start = btn;
      bus.hit       = h;
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0);
      stepEdge();
      stepEdge();
      reset = 1'b0;
   endtask

   task automatic startRun();
      applyStimulus(1'b1, 1'b0);
      repeat (3) stepEdge();
      applyStimulus(1'b0, 1'b0);
   endtask

   task automatic test_reset();
      doReset();
      checks++;
      if (bus.running !== 1'b0) begin failures++; $display("[TB] FAIL reset_running got=%b exp=0", bus.running); end
      checks++;
      if (bus.game_over !== 1'b0) begin failures++; $display("[TB] FAIL reset_game_over got=%b exp=0", bus.game_over); end
      checks++;
      if (bus.score_bcd !== 16'h0000) begin failures++; $display("[TB] FAIL reset_score got=%h exp=0000", bus.score_bcd); end
      checks++;
      if (bus.level !== 3'd0 || bus.level_up !== 1'b0) begin failures++; $display("[TB] FAIL reset_level got=%0d/%b exp=0/0", bus.level, bus.level_up); end
      checks++;
      if (bus.hi_score_bcd !== 16'h0000) begin failures++; $display("[TB] FAIL reset_hi got=%h exp=0000", bus.hi_score_bcd); end
      stepEdge();
      checks++;
      if (bus.running !== 1'b0) begin failures++; $display("[TB] FAIL idle_hold got=%b exp=0", bus.running); end
   endtask

   task automatic test_start();
      logic [2:0] expRun;
      doReset();
      expRun = 3'b100;
      applyStimulus(1'b1, 1'b0);
      for (int e = 0; e < 3; e++) begin
         stepEdge();
         checks++;
         if (bus.running !== expRun[e]) begin failures++; $display("[TB] FAIL start_latency_e%0d got=%b exp=%b", e + 1, bus.running, expRun[e]); end
      end
      applyStimulus(1'b0, 1'b0);
      checks++;
      if (bus.score_bcd !== 16'h0000) begin failures++; $display("[TB] FAIL start_score got=%h exp=0000", bus.score_bcd); end
      for (int i = 1; i <= 3; i++) begin
         stepEdge();
         checks++;
         if (bus.score_bcd !== 16'(i)) begin failures++; $display("[TB] FAIL count_%0d got=%h exp=%h", i, bus.score_bcd, 16'(i)); end
      end
   endtask

   task automatic test_levels();
      int pulses;
      int firstAt;
      int secondAt;
      doReset();
      startRun();
      pulses   = 0;
      firstAt  = -1;
      secondAt = -1;
      for (int i = 1; i <= 250; i++) begin
         stepEdge();
         if (bus.level_up === 1'b1) begin
            pulses++;
            if (pulses == 1) firstAt = i;
            if (pulses == 2) secondAt = i;
         end
      end
      checks++;
      if (bus.score_bcd !== 16'h0250) begin failures++; $display("[TB] FAIL run250_score got=%h exp=0250", bus.score_bcd); end
      checks++;
      if (bus.level !== 3'd2) begin failures++; $display("[TB] FAIL run250_level got=%0d exp=2", bus.level); end
      checks++;
      if (pulses != 2 || firstAt != 100 || secondAt != 200) begin
         failures++;
         $display("[TB] FAIL level_up_pulses got=%0d@%0d,%0d exp=2@100,200", pulses, firstAt, secondAt);
      end
   endtask

   task automatic test_hit();
      doReset();
      startRun();
      repeat (42) stepEdge();
      checks++;
      if (bus.score_bcd !== 16'h0042) begin failures++; $display("[TB] FAIL hit_pre_score got=%h exp=0042", bus.score_bcd); end
      applyStimulus(1'b0, 1'b1);
      stepEdge();
      stepEdge();
      checks++;
      if (bus.game_over !== 1'b0 || bus.running !== 1'b1) begin failures++; $display("[TB] FAIL hit_sync_lag got=%b%b exp=01", bus.game_over, bus.running); end
      stepEdge();
      checks++;
      if (bus.game_over !== 1'b1 || bus.running !== 1'b0) begin failures++; $display("[TB] FAIL hit_over got=%b%b exp=10", bus.game_over, bus.running); end
      checks++;
      if (bus.score_bcd !== 16'h0044) begin failures++; $display("[TB] FAIL hit_freeze got=%h exp=0044", bus.score_bcd); end
      stepEdge();
      stepEdge();
      checks++;
      if (bus.score_bcd !== 16'h0044) begin failures++; $display("[TB] FAIL over_frozen got=%h exp=0044", bus.score_bcd); end
      applyStimulus(1'b1, 1'b1);
      repeat (4) stepEdge();
      checks++;
      if (bus.game_over !== 1'b1) begin failures++; $display("[TB] FAIL over_start_blocked got=%b exp=1", bus.game_over); end
      applyStimulus(1'b0, 1'b0);
      repeat (3) stepEdge();
      applyStimulus(1'b1, 1'b0);
      repeat (3) stepEdge();
      applyStimulus(1'b0, 1'b0);
      checks++;
      if (bus.game_over !== 1'b0 || bus.running !== 1'b0 || bus.score_bcd !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL over_to_idle got=%b%b/%h exp=00/0000", bus.game_over, bus.running, bus.score_bcd);
      end
   endtask

   task automatic test_saturation();
      int pulses;
      doReset();
      startRun();
      pulses = 0;
      for (int i = 1; i <= 9998; i++) begin
         stepEdge();
         if (bus.level_up === 1'b1) pulses++;
      end
      checks++;
      if (bus.score_bcd !== 16'h9998) begin failures++; $display("[TB] FAIL sat_pre got=%h exp=9998", bus.score_bcd); end
      checks++;
      if (bus.level !== 3'd7 || pulses != 7) begin failures++; $display("[TB] FAIL level_cap got=%0d/%0d exp=7/7", bus.level, pulses); end
      for (int i = 0; i < 3; i++) begin
         stepEdge();
         checks++;
         if (bus.score_bcd !== 16'h9999) begin failures++; $display("[TB] FAIL sat_hold_%0d got=%h exp=9999", i, bus.score_bcd); end
      end
   endtask

   task automatic test_hiscore();
      doReset();
      startRun();
      repeat (118) stepEdge();
      applyStimulus(1'b0, 1'b1);
      repeat (3) stepEdge();
      checks++;
      if (bus.game_over !== 1'b1 || bus.score_bcd !== 16'h0120) begin failures++; $display("[TB] FAIL game1_end got=%b/%h exp=1/0120", bus.game_over, bus.score_bcd); end
      checks++;
      if (bus.hi_score_bcd !== HI_AFTER_G1) begin failures++; $display("[TB] FAIL hi_game1 got=%h exp=%h", bus.hi_score_bcd, HI_AFTER_G1); end
      applyStimulus(1'b0, 1'b0);
      repeat (3) stepEdge();
      applyStimulus(1'b1, 1'b0);
      repeat (3) stepEdge();
      applyStimulus(1'b0, 1'b0);
      repeat (3) stepEdge();
      startRun();
      repeat (78) stepEdge();
      applyStimulus(1'b0, 1'b1);
      repeat (3) stepEdge();
      checks++;
      if (bus.game_over !== 1'b1 || bus.score_bcd !== 16'h0080) begin failures++; $display("[TB] FAIL game2_end got=%b/%h exp=1/0080", bus.game_over, bus.score_bcd); end
      checks++;
      if (bus.hi_score_bcd !== HI_AFTER_G2) begin failures++; $display("[TB] FAIL hi_game2 got=%h exp=%h", bus.hi_score_bcd, HI_AFTER_G2); end
   endtask

   task automatic test_reset_mid_run();
      doReset();
      startRun();
      repeat (150) stepEdge();
      applyStimulus(1'b0, 1'b1);
      stepEdge();
      reset = 1'b1;
      stepEdge();
      checks++;
      if (bus.running !== 1'b0 || bus.game_over !== 1'b0 || bus.level_up !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midrun_reset_flags got=%b%b%b exp=000", bus.running, bus.game_over, bus.level_up);
      end
      checks++;
      if (bus.score_bcd !== 16'h0000 || bus.level !== 3'd0 || bus.hi_score_bcd !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL midrun_reset_values got=%h/%0d/%h exp=0000/0/0000", bus.score_bcd, bus.level, bus.hi_score_bcd);
      end
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0);
      repeat (2) stepEdge();
      checks++;
      if (bus.running !== 1'b0 || bus.score_bcd !== 16'h0000) begin failures++; $display("[TB] FAIL post_reset_idle got=%b/%h exp=0/0000", bus.running, bus.score_bcd); end
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0);
      test_reset();
      test_start();
      test_levels();
      test_hit();
      test_saturation();
      test_hiscore();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
